// File: rtl/binary_window_filter.sv
// Streaming 1-D binary neighbourhood filter: dilate / erode / edge / ones-threshold
// over a WIN-pixel window, with PAD fill at line edges and an end-of-line flush.
module binary_window_filter #(
  parameter int unsigned WIN = 5,
  parameter logic        PAD = 1'b0,
  parameter int unsigned CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_pix,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] thr,
  output logic          out_valid,
  output logic          out_pix,
  output logic          out_last,
  output logic [CW-1:0] out_ones
);

  localparam int unsigned H   = (WIN - 1) / 2;
  localparam int unsigned SW  = (H > 0) ? $clog2(H + 1) : 1;
  localparam int unsigned HM1 = (H > 0) ? H - 1 : 0;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state;
  logic [WIN-1:0]  win_q;
  logic [SW-1:0]   s_q;
  logic [SW-1:0]   fcnt;
  logic [1:0]      mode_q;
  logic [CW-1:0]   thr_q;

  logic            accept;
  logic            start;
  logic            shift_en;
  logic            shift_val;
  logic            end_line;
  logic            flush_done;
  logic            last_shift;
  logic            emit;
  logic            res_pix;
  logic [SW-1:0]   s_cur;
  logic [SW-1:0]   s_nx;
  logic [WIN-1:0]  win_base;
  logic [WIN-1:0]  win_nx;
  logic [CW-1:0]   n;
  logic [1:0]      mode_eff;
  logic [CW-1:0]   thr_eff;
  logic            oldest_unused;

  // The oldest pixel simply falls out of the window on each shift.
  assign oldest_unused = win_q[WIN-1];

  // Shift control, post-shift window and filter result for this cycle.
  always_comb begin
    accept     = in_valid & in_ready;
    start      = accept & in_first;
    shift_en   = 1'b0;
    shift_val  = PAD;
    end_line   = 1'b0;
    flush_done = 1'b0;
    s_cur      = s_q;
    win_base   = win_q;
    case (state)
      IDLE: begin
        if (start) begin
          shift_en  = 1'b1;
          shift_val = in_pix;
          end_line  = in_last;
          s_cur     = '0;
          win_base  = {WIN{PAD}};
        end
      end
      RUN: begin
        if (accept) begin
          shift_en  = 1'b1;
          shift_val = in_pix;
          end_line  = in_last;
          if (in_first) begin
            s_cur    = '0;
            win_base = {WIN{PAD}};
          end
        end
      end
      FLUSH: begin
        shift_en   = 1'b1;
        flush_done = (fcnt == SW'(HM1));
      end
      default: ;
    endcase

    win_nx[0] = shift_val;
    for (int i = 1; i < WIN; i++) win_nx[i] = win_base[i-1];

    n = '0;
    for (int i = 0; i < WIN; i++) n = n + CW'(win_nx[i]);

    s_nx       = (s_cur >= SW'(H)) ? SW'(H) : s_cur + 1'b1;
    emit       = shift_en & (s_cur >= SW'(H));
    last_shift = (H == 0) ? end_line : flush_done;

    // A line start applies its own mode/thr to its first result already.
    mode_eff = start ? mode : mode_q;
    thr_eff  = start ? thr  : thr_q;
    case (mode_eff)
      2'd0:    res_pix = (n != '0);
      2'd1:    res_pix = (n == CW'(WIN));
      2'd2:    res_pix = win_nx[H] & (n != CW'(WIN));
      default: res_pix = (n >= thr_eff);
    endcase
  end

  // State, window and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_q     <= {WIN{PAD}};
      s_q       <= '0;
      fcnt      <= '0;
      mode_q    <= '0;
      thr_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_pix   <= 1'b0;
      out_last  <= 1'b0;
      out_ones  <= '0;
    end else begin
      out_valid <= emit;
      out_last  <= emit & last_shift;
      if (emit) begin
        out_pix  <= res_pix;
        out_ones <= n;
      end
      if (shift_en) begin
        win_q <= win_nx;
        s_q   <= s_nx;
      end
      if (start) begin
        mode_q <= mode;
        thr_q  <= thr;
      end
      case (state)
        IDLE, RUN: begin
          if (shift_en) begin
            if (end_line) begin
              if (H > 0) begin
                state    <= FLUSH;
                in_ready <= 1'b0;
                fcnt     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= RUN;
            end
          end
        end
        FLUSH: begin
          if (flush_done) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
